// File: rtl/dcc_packet_scheduler.sv
// DCC command scheduler: host-loaded command table with an urgent repeat queue,
// round-robin refresh of valid slots and idle-packet fallback.
module dcc_packet_scheduler #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned URGENT_REPEAT = 3,
    parameter int unsigned UQ_DEPTH      = 4,
    parameter logic [15:0] IDLE_WORD     = 16'hFF00,
    localparam int unsigned AW           = $clog2(DEPTH),
    localparam int unsigned UQW          = $clog2(UQ_DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_slot,
    input  logic          wr_en,
    input  logic [15:0]   wr_word,
    input  logic [9:0]    cmd_index,
    output logic [31:0]   cmd_word,
    output logic [AW-1:0] cur_slot,
    output logic          cur_idle,
    output logic          cur_urgent,
    output logic [UQW:0]  uq_count
);

    localparam logic [3:0]   RPT_LAST = 4'(URGENT_REPEAT - 1);
    localparam logic [UQW:0] UQ_FULL  = (UQW+1)'(UQ_DEPTH);

    logic [DEPTH-1:0] valid_q;
    logic [15:0]      word_q   [DEPTH];
    logic [AW-1:0]    uq_mem_q [UQ_DEPTH];

    logic [UQW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [UQW:0]   cnt_q, cnt_d;
    logic [3:0]     rpt_q, rpt_d;
    logic [AW-1:0]  rr_q, rr_d;
    logic [9:0]     idx_q;
    logic [15:0]    word_out_q, word_out_d;
    logic [AW-1:0]  slot_q, slot_d;
    logic           idle_q, idle_d, urgent_q, urgent_d;

    logic          adv, accept, push, pop, uq_empty, head_ok, urgent_sel;
    logic [AW-1:0] head;
    logic          rf_found;
    logic [AW-1:0] rf_slot, cand;

    assign adv      = (cmd_index != idx_q);
    assign wr_ready = (cnt_q != UQ_FULL);
    assign accept   = wr_valid && wr_ready;
    assign push     = accept && wr_en;
    assign uq_empty = (cnt_q == '0);
    assign head     = uq_mem_q[rd_ptr_q];
    assign head_ok  = valid_q[head];

    // Selection uses pre-write table state; an invalid head is popped and the
    // packet falls through to refresh in the same advance.
    assign urgent_sel = adv && !uq_empty && head_ok;
    assign pop        = adv && !uq_empty && (!head_ok || rpt_q == RPT_LAST);

    always_comb begin
        rf_found = 1'b0;
        rf_slot  = '0;
        cand     = '0;
        for (int unsigned i = 1; i <= DEPTH; i++) begin
            cand = rr_q + AW'(i);
            if (!rf_found && valid_q[cand]) begin
                rf_found = 1'b1;
                rf_slot  = cand;
            end
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        rpt_d      = rpt_q;
        rr_d       = rr_q;
        word_out_d = word_out_q;
        slot_d     = slot_q;
        idle_d     = idle_q;
        urgent_d   = urgent_q;

        if (push) wr_ptr_d = wr_ptr_q + UQW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + UQW'(1);
        if (push && !pop)      cnt_d = cnt_q + (UQW+1)'(1);
        else if (pop && !push) cnt_d = cnt_q - (UQW+1)'(1);

        if (pop)             rpt_d = '0;
        else if (urgent_sel) rpt_d = rpt_q + 4'd1;

        if (adv) begin
            if (urgent_sel) begin
                word_out_d = word_q[head];
                slot_d     = head;
                idle_d     = 1'b0;
                urgent_d   = 1'b1;
            end else if (rf_found) begin
                word_out_d = word_q[rf_slot];
                slot_d     = rf_slot;
                rr_d       = rf_slot;
                idle_d     = 1'b0;
                urgent_d   = 1'b0;
            end else begin
                word_out_d = IDLE_WORD;
                slot_d     = '0;
                idle_d     = 1'b1;
                urgent_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            rpt_q      <= '0;
            rr_q       <= '1;
            idx_q      <= '0;
            word_out_q <= IDLE_WORD;
            slot_q     <= '0;
            idle_q     <= 1'b1;
            urgent_q   <= 1'b0;
        end else begin
            if (accept) begin
                valid_q[wr_slot] <= wr_en;
                if (wr_en) word_q[wr_slot] <= wr_word;
            end
            if (push) uq_mem_q[wr_ptr_q] <= wr_slot;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            rpt_q      <= rpt_d;
            rr_q       <= rr_d;
            idx_q      <= cmd_index;
            word_out_q <= word_out_d;
            slot_q     <= slot_d;
            idle_q     <= idle_d;
            urgent_q   <= urgent_d;
        end
    end

    assign cmd_word   = {16'h0000, word_out_q};
    assign cur_slot   = slot_q;
    assign cur_idle   = idle_q;
    assign cur_urgent = urgent_q;
    assign uq_count   = cnt_q;

endmodule

// File: tb/tb_dcc_packet_scheduler.sv
// Directed bench for dcc_packet_scheduler: urgent repeats, round-robin refresh,
// disable-while-queued, queue backpressure, output stability and reset.
module tb_dcc_packet_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_slot;
    logic        wr_en;
    logic [15:0] wr_word;
    logic [9:0]  cmd_index;
    logic [31:0] cmd_word;
    logic [3:0]  cur_slot;
    logic        cur_idle;
    logic        cur_urgent;
    logic [2:0]  uq_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    dcc_packet_scheduler #(
        .DEPTH(16),
        .URGENT_REPEAT(3),
        .UQ_DEPTH(4),
        .IDLE_WORD(16'hFF00)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_slot   (wr_slot),
        .wr_en     (wr_en),
        .wr_word   (wr_word),
        .cmd_index (cmd_index),
        .cmd_word  (cmd_word),
        .cur_slot  (cur_slot),
        .cur_idle  (cur_idle),
        .cur_urgent(cur_urgent),
        .uq_count  (uq_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bump();
        cmd_index = cmd_index + 10'd1;
        tick();
    endtask

    task automatic host_write(input logic [3:0] slot, input logic en, input logic [15:0] word);
        check_eq("wr_ready_before_write", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_slot  = slot;
        wr_en    = en;
        wr_word  = word;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic expect_pkt(input string tag, input logic [15:0] word, input logic [3:0] slot,
                              input logic idle, input logic urgent);
        check_eq({tag, "_word"}, cmd_word, {16'h0000, word});
        check_eq({tag, "_slot"}, 32'(cur_slot), 32'(slot));
        check_eq({tag, "_idle"}, 32'(cur_idle), 32'(idle));
        check_eq({tag, "_urg"}, 32'(cur_urgent), 32'(urgent));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_exp [6];
        rr_exp = '{4'd5, 4'd9, 4'd1, 4'd5, 4'd9, 4'd1};

        reset_n   = 1'b0;
        wr_valid  = 1'b0;
        wr_slot   = '0;
        wr_en     = 1'b0;
        wr_word   = '0;
        cmd_index = '0;
        tick();
        tick();
        reset_n = 1'b1;

        // Reset state and empty-table idle packets.
        expect_pkt("rst", 16'hFF00, 4'd0, 1'b1, 1'b0);
        check_eq("rst_uq_count", 32'(uq_count), 32'd0);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        tick();
        expect_pkt("static", 16'hFF00, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bump();
            expect_pkt("empty_step", 16'hFF00, 4'd0, 1'b1, 1'b0);
        end

        // Urgent repeat: three urgent sends, then refresh of the same slot.
        host_write(4'd2, 1'b1, 16'h0360);
        check_eq("urg_uq_count_1", 32'(uq_count), 32'd1);
        for (int i = 0; i < 3; i++) begin
            bump();
            expect_pkt("urg", 16'h0360, 4'd2, 1'b0, 1'b1);
        end
        check_eq("urg_uq_count_0", 32'(uq_count), 32'd0);
        for (int i = 0; i < 2; i++) begin
            bump();
            expect_pkt("urg_refresh", 16'h0360, 4'd2, 1'b0, 1'b0);
        end

        // Round-robin over slots 1, 5, 9 (rr is 2 here).
        host_write(4'd2, 1'b0, 16'hDEAD);
        host_write(4'd1, 1'b1, 16'h0101);
        host_write(4'd5, 1'b1, 16'h0505);
        host_write(4'd9, 1'b1, 16'h0909);
        check_eq("rr_uq_count_3", 32'(uq_count), 32'd3);
        for (int i = 0; i < 9; i++) begin
            bump();
            case (i / 3)
                0:       expect_pkt("drain1", 16'h0101, 4'd1, 1'b0, 1'b1);
                1:       expect_pkt("drain5", 16'h0505, 4'd5, 1'b0, 1'b1);
                default: expect_pkt("drain9", 16'h0909, 4'd9, 1'b0, 1'b1);
            endcase
        end
        check_eq("rr_uq_drained", 32'(uq_count), 32'd0);
        for (int i = 0; i < 6; i++) begin
            bump();
            check_eq("rr_slot", 32'(cur_slot), 32'(rr_exp[i]));
            check_eq("rr_word", cmd_word, {16'h0000, rr_exp[i], 4'h0, rr_exp[i], 4'h0} >> 4 | 32'(rr_exp[i]));
            check_eq("rr_urg", 32'(cur_urgent), 32'd0);
        end

        // Disable while queued: head popped, refresh continues from rr=1.
        host_write(4'd4, 1'b1, 16'h0444);
        host_write(4'd4, 1'b0, 16'h0000);
        check_eq("dis_uq_count_1", 32'(uq_count), 32'd1);
        bump();
        expect_pkt("dis_step", 16'h0505, 4'd5, 1'b0, 1'b0);
        check_eq("dis_uq_count_0", 32'(uq_count), 32'd0);
        host_write(4'd1, 1'b0, 16'h0000);
        host_write(4'd5, 1'b0, 16'h0000);
        host_write(4'd9, 1'b0, 16'h0000);
        bump();
        expect_pkt("all_disabled", 16'hFF00, 4'd0, 1'b1, 1'b0);

        // Backpressure: four writes fill the queue, fifth waits for a pop.
        host_write(4'd3, 1'b1, 16'h0333);
        host_write(4'd6, 1'b1, 16'h0666);
        host_write(4'd7, 1'b1, 16'h0777);
        host_write(4'd8, 1'b1, 16'h0888);
        check_eq("bp_full_count", 32'(uq_count), 32'd4);
        check_eq("bp_full_ready", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1;
        wr_slot  = 4'd10;
        wr_en    = 1'b1;
        wr_word  = 16'h0AAA;
        tick();
        check_eq("bp_held_count", 32'(uq_count), 32'd4);
        for (int i = 0; i < 3; i++) begin
            bump();
            expect_pkt("bp_urg3", 16'h0333, 4'd3, 1'b0, 1'b1);
        end
        check_eq("bp_pop_count", 32'(uq_count), 32'd3);
        check_eq("bp_pop_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        check_eq("bp_accept_count", 32'(uq_count), 32'd4);
        check_eq("bp_accept_ready", 32'(wr_ready), 32'd0);

        // Stability: overwrite the slot on the track without an advance.
        for (int i = 0; i < 3; i++) begin
            bump();
            expect_pkt("st_urg6", 16'h0666, 4'd6, 1'b0, 1'b1);
        end
        host_write(4'd6, 1'b1, 16'h6666);
        tick();
        tick();
        expect_pkt("st_hold", 16'h0666, 4'd6, 1'b0, 1'b1);
        bump();
        expect_pkt("st_next7", 16'h0777, 4'd7, 1'b0, 1'b1);

        // Reset mid-sequence, then confirm the table was discarded.
        reset_n   = 1'b0;
        cmd_index = '0;
        tick();
        reset_n = 1'b1;
        expect_pkt("rst2", 16'hFF00, 4'd0, 1'b1, 1'b0);
        check_eq("rst2_uq_count", 32'(uq_count), 32'd0);
        check_eq("rst2_wr_ready", 32'(wr_ready), 32'd1);
        bump();
        expect_pkt("rst2_step", 16'hFF00, 4'd0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dcc_packet_scheduler.md
# dcc_packet_scheduler

Command scheduler for the DCC track packet generator. Holds a table of per-decoder commands loaded by the host, decides which command goes on the track next, and presents it on the generator's `cmd_word` input, advancing whenever the generator's `cmd_index` changes. Freshly written commands are sent several times back-to-back. After that, valid table entries are refreshed round-robin, and the DCC idle packet is sent when the table is empty.

## Interface
- `DEPTH`, default 16: number of command slots; must be a power of 2, with AW = log2(DEPTH).
- `URGENT_REPEAT`, default 3: consecutive sends of a newly written command (1..15).
- `UQ_DEPTH`, default 4: urgent queue depth (power of 2).
- `IDLE_WORD`, default 16'hFF00: idle packet, address 8'hFF and instruction 8'h00.
- `clk`, in, 1: clock, rising edge.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `wr_valid`, in, 1: host write request.
- `wr_ready`, out, 1: write accepted when both valid and ready are high.
- `wr_slot`, in, AW: target slot.
- `wr_en`, in, 1: 1 loads and enables the slot; 0 disables it (the word is ignored).
- `wr_word`, in, 16: bits [15:8] are the decoder address; bits [7:0] are the instruction byte.
- `cmd_index`, in, 10: packet counter from the generator; it changes by +1 (wrapping) at each packet end.
- `cmd_word`, out, 32: bits [31:16] are 0 and bits [15:0] are the selected command word.
- `cur_slot`, out, AW: slot of the current `cmd_word` (0 when idle).
- `cur_idle`, out, 1: current packet is the idle packet.
- `cur_urgent`, out, 1: current packet came from the urgent queue.
- `uq_count`, out, log2(UQ_DEPTH)+1: urgent queue occupancy.

## Operation
**Storage**
- Table: DEPTH entries, each a `valid` bit plus a 16-bit word.
- Urgent queue: FIFO of slot numbers, plus a repeat counter `rpt` for the head entry.
- Round-robin pointer `rr` of AW bits.

**Host writes**
- `wr_ready` = queue not full. This applies to all writes, including disables.
- Accepted write with `wr_en`=1: sets word and valid=1, and pushes `wr_slot` into the urgent queue.
- Accepted write with `wr_en`=0: clears valid and pushes nothing.
- The table updates at the accepting edge.

**Advance**
- Signal: `adv` = (`cmd_index` != `idx_q`), where `idx_q` is a registered copy of `cmd_index`, updated every cycle.

**Selection on adv**, using state as it stood before the same-cycle write:
1. If the queue is not empty and the head slot is valid: select the head and set `cur_urgent`=1.
   - `rpt`+1; when `rpt` reaches URGENT_REPEAT, pop the head and clear `rpt` to 0.
2. If the head slot is invalid: pop it, clear `rpt`, then fall to step 3 for this packet.
3. Otherwise, refresh: take the first valid slot searching `rr`+1, `rr`+2, … with wrap, ending at `rr` itself. Select it and set `rr` to it.
4. If no slot is valid: select IDLE_WORD, set `cur_idle`=1 and `cur_slot`=0; `rr` is unchanged.

**Output stability**
- `cmd_word` is a snapshot register, written only on `adv`.
- Table writes, including writes to `cur_slot`, never alter `cmd_word` between advances.

**Simultaneous events**
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- With the queue full, a pop frees space next cycle; `wr_ready` is combinational from the registered count.
- A write racing with `adv` becomes visible at the following `adv`.

**Reset values**
- Table all invalid, queue empty, `rpt`=0, `rr`=DEPTH-1.
- `idx_q`=0, `cmd_word`=32'h0000FF00, `cur_slot`=0, `cur_idle`=1, `cur_urgent`=0, `uq_count`=0, `wr_ready`=1.
- Reset mid-operation discards all table and queue contents immediately.

## Timing
- `adv` is asserted in the same cycle `cmd_index` changes.
- `cmd_word` and the `cur_*` outputs update at that cycle's closing edge, a latency of 1 cycle.
- This is well before the generator samples `cmd_word`, which happens after the preamble.
- Only one `adv` per `cmd_index` change.
- A `cmd_index` change arriving on consecutive cycles is handled each cycle, with no minimum spacing required.
- Write acceptance is single-cycle; the written slot becomes eligible at the next `adv`.
- `uq_count` updates at the clock edge.

## Test plan
- **Reset, empty table:** hold `cmd_index` static, then step it 3 times → `cmd_word` stays 32'h0000FF00, `cur_idle`=1 throughout.
- **Urgent repeat:** write slot 2 = 16'h0360, then step 5 times → three packets of 16'h0360 with `cur_urgent`=1, then two refresh packets of 16'h0360 with `cur_urgent`=0; `uq_count` returns to 0.
- **Round-robin:** enable slots 1, 5, 9 and drain the queue, then step 6 times → slot sequence advances through 1, 5, 9 in cyclic order; no other slots selected.
- **Disable while queued:** write slot 4, then disable slot 4 before any step, then step → slot 4 never sent, head popped, refresh/idle selected; `uq_count`=0.
- **Backpressure:** issue 5 writes with no steps → `wr_ready`=0 after 4 acceptances, 5th held until first pop (after 3 steps), then accepted.
- **Stability and reset:** overwrite `cur_slot` mid-packet → `cmd_word` unchanged until next step. Assert `reset_n`=0 for 1 cycle mid-sequence → all outputs at reset values next cycle.
